uart_bus_master: RTL



---
 rtl/uart_bus_master_pkg.sv | 18 +
 rtl/uart_bus_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master_pkg.sv
// rtl/uart_bus_master_pkg.sv - command/reply byte codes and FSM state encoding
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte-command bridge mastering the native memory bus
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int BUS_TIMEOUT  = 1024,
  parameter int BYTE_TIMEOUT = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        bus_err,
  output logic        rx_overrun
);

  localparam int MAX_TO = (BUS_TIMEOUT > BYTE_TIMEOUT) ? BUS_TIMEOUT : BYTE_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO + 1);
  localparam logic [CNT_W-1:0] BUS_LAST  = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_idx;
  logic [31:0]      r_shift;
  logic [31:0]      r_addr;
  logic [31:0]      r_reply;
  logic [2:0]       r_left;
  logic             r_is_wr;
  logic             r_mem_valid;
  logic             r_bus_err;
  logic             r_rx_overrun;
  logic [CNT_W-1:0] r_cnt;

  logic             w_field_done;
  logic             w_byte_to;
  logic             w_bus_done;
  logic             w_bus_to;
  logic             w_is_cmd;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_field_done = rx_valid && (r_idx == 2'd3);
  assign w_byte_to    = !rx_valid && (r_cnt == BYTE_LAST);
  assign w_bus_done   = r_mem_valid && mem_ready;
  assign w_bus_to     = r_mem_valid && !mem_ready && (r_cnt == BUS_LAST);
  assign w_is_cmd     = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  assign tx_valid   = (r_state == ST_RESP);
  assign tx_data    = r_reply[31:24];
  assign mem_valid  = r_mem_valid;
  assign mem_instr  = 1'b0;
  assign mem_addr   = r_addr;
  // The field shifter holds the write data once the DATA field is complete.
  assign mem_wdata  = r_shift;
  assign mem_wstrb  = r_is_wr ? 4'hF : 4'h0;
  assign busy       = (r_state != ST_IDLE);
  assign bus_err    = r_bus_err;
  assign rx_overrun = r_rx_overrun;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode from received bytes, bus completion and reply drain.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (rx_valid) w_next_state = w_is_cmd ? ST_ADDR : ST_RESP;
      ST_ADDR: begin
        if (w_field_done)   w_next_state = r_is_wr ? ST_DATA : ST_BUS;
        else if (w_byte_to) w_next_state = ST_IDLE;
      end
      ST_DATA: begin
        if (w_field_done)   w_next_state = ST_BUS;
        else if (w_byte_to) w_next_state = ST_IDLE;
      end
      ST_BUS:  if (w_bus_done || w_bus_to) w_next_state = ST_RESP;
      ST_RESP: if (tx_ready && (r_left == 3'd1)) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: field shifting, bus request, reply buffer, shared timeout counter, flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= 2'd0;
      r_shift      <= 32'd0;
      r_addr       <= 32'd0;
      r_reply      <= 32'd0;
      r_left       <= 3'd0;
      r_is_wr      <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_bus_err    <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx <= 2'd0;
          r_cnt <= '0;
          if (rx_valid) begin
            r_is_wr <= (rx_data == CMD_WR);
            if (!w_is_cmd) begin
              r_reply <= {RSP_UNK, 24'd0};
              r_left  <= 3'd1;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          r_cnt <= rx_valid ? '0 : w_cnt_inc;
          if (rx_valid) begin
            r_shift <= {r_shift[23:0], rx_data};
            r_idx   <= r_idx + 2'd1;
          end
          if (w_field_done && (r_state == ST_ADDR))
            r_addr <= {r_shift[23:0], rx_data[7:2], 2'b00};
          if (w_next_state == ST_BUS)
            r_mem_valid <= 1'b1;
        end
        ST_BUS: begin
          r_cnt <= w_cnt_inc;
          if (w_bus_done) begin
            r_mem_valid <= 1'b0;
            r_reply     <= r_is_wr ? {RSP_OK, 24'd0} : mem_rdata;
            r_left      <= r_is_wr ? 3'd1 : 3'd4;
          end else if (w_bus_to) begin
            r_mem_valid <= 1'b0;
            r_bus_err   <= 1'b1;
            r_reply     <= {RSP_ERR, 24'd0};
            r_left      <= 3'd1;
          end
        end
        ST_RESP: begin
          r_cnt <= '0;
          if (tx_ready) begin
            r_reply <= {r_reply[23:0], 8'h00};
            r_left  <= r_left - 3'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
      if (rx_valid && ((r_state == ST_BUS) || (r_state == ST_RESP)))
        r_rx_overrun <= 1'b1;
    end
  end

endmodule
